// File: rtl/bfs_iteration_ctrl.sv
// -----------------------------------------------------------------------------
// bfs_iteration_ctrl
//
// Top-level BFS iteration sequencer. It holds the per-core pipeline in reset,
// injects the root vertex, then runs iterations. Each iteration collects
// iteration-end flags from every core into a sticky mask and counts updated
// active vertices. Once every core has ended, the controller either opens the
// next iteration or declares convergence.
//
// Optional build macro:
//   ITER_TIMEOUT_EN - adds a per-iteration watchdog. If an iteration stays in
//                     RUN for TIMEOUT_CYCLES cycles, the controller ends the
//                     run with timeout=1. Without the macro, timeout is tied
//                     to 0 and RUN waits for the mask indefinitely.
//
// Parameters:
//   CORE_NUM        number of cores (power of two, 2..64)
//   V_ID_WIDTH      vertex id width
//   ITER_WIDTH      iteration counter width
//   MAX_ITER        iteration cap (<= 2^ITER_WIDTH-1)
//   RST_CYCLES      core reset pulse length (1..15)
//   TIMEOUT_CYCLES  watchdog limit (ITER_TIMEOUT_EN only)
//
// Ports:
//   clk                  single clock
//   rst                  asynchronous active-low reset
//   start                launch pulse, honoured only in IDLE or DONE
//   root_v_id            root vertex, sampled on an accepted start
//   active_v_valid       per-core active-vertex valid
//   active_v_updated     per-core active-vertex updated flag
//   iteration_end        per-core iteration-end flag
//   iteration_end_valid  qualifies iteration_end
//   core_rst             synchronous active-high reset to the cores (all equal)
//   seed_v_id            latched root id, meaningful with seed_valid
//   seed_valid           one-cycle root injection
//   iter_start           one-cycle pulse opening every iteration
//   iter_id              current iteration index, starting at 0
//   upd_count            saturating updated-vertex count of this iteration
//   busy                 high in every state except IDLE and DONE
//   done                 level, high in DONE
//   cap_hit              DONE was reached through MAX_ITER
//   timeout              DONE was reached through the watchdog
// -----------------------------------------------------------------------------
module bfs_iteration_ctrl #(
    parameter int CORE_NUM       = 32,
    parameter int V_ID_WIDTH     = 32,
    parameter int ITER_WIDTH     = 16,
    parameter int MAX_ITER       = 65535,
    parameter int RST_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1 << 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [V_ID_WIDTH-1:0] root_v_id,
    input  logic [CORE_NUM-1:0]   active_v_valid,
    input  logic [CORE_NUM-1:0]   active_v_updated,
    input  logic [CORE_NUM-1:0]   iteration_end,
    input  logic [CORE_NUM-1:0]   iteration_end_valid,
    output logic [CORE_NUM-1:0]   core_rst,
    output logic [V_ID_WIDTH-1:0] seed_v_id,
    output logic                  seed_valid,
    output logic                  iter_start,
    output logic [ITER_WIDTH-1:0] iter_id,
    output logic [31:0]           upd_count,
    output logic                  busy,
    output logic                  done,
    output logic                  cap_hit,
    output logic                  timeout
);

    localparam int                    CNT_W    = $clog2(CORE_NUM + 1);
    localparam logic [3:0]            RST_LAST = 4'(RST_CYCLES - 1);
    localparam logic [ITER_WIDTH-1:0] ITER_CAP = ITER_WIDTH'(MAX_ITER);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SEED,
        S_RUN,
        S_CHECK,
        S_NEXT,
        S_DONE
    } state_t;

    state_t              state;
    logic [3:0]          rst_cnt;
    logic [CORE_NUM-1:0] end_mask;

    // -------------------------------------------------------------------------
    // Combinational datapath
    // -------------------------------------------------------------------------

    // Adder tree over the qualified update flags; the result feeds upd_count
    // directly, so there is exactly one register stage on this path.
    function automatic logic [CNT_W-1:0] popcount(input logic [CORE_NUM-1:0] v);
        logic [CNT_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < CORE_NUM; i++) begin
            sum = sum + CNT_W'(v[i]);
        end
        return sum;
    endfunction

    logic [CNT_W-1:0]    upd_pop;
    logic [32:0]         upd_sum;
    logic [31:0]         upd_sat;
    logic [CORE_NUM-1:0] mask_merged;
    logic                mask_full;
    logic                launch;
    logic                wd_expire;

    assign upd_pop = popcount(active_v_valid & active_v_updated);
    assign upd_sum = {1'b0, upd_count} + 33'(upd_pop);
    // The carry out of the 33-bit sum means the 32-bit count has wrapped,
    // so pin it at all-ones instead.
    assign upd_sat = upd_sum[32] ? '1 : upd_sum[31:0];

    // The incoming ends are OR-ed in combinationally so RUN can leave in the
    // same cycle the last core reports. A valid end=0 contributes nothing,
    // so it cannot clear a bit that is already set.
    assign mask_merged = end_mask | (iteration_end_valid & iteration_end);
    assign mask_full   = &mask_merged;

    assign launch = start && ((state == S_IDLE) || (state == S_DONE));

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
    // NOTE: state and registered outputs use non-blocking assignments only, so
    // every branch reads the values held before this clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            rst_cnt    <= '0;
            end_mask   <= '0;
            core_rst   <= '1;
            seed_v_id  <= '0;
            seed_valid <= 1'b0;
            iter_start <= 1'b0;
            iter_id    <= '0;
            upd_count  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cap_hit    <= 1'b0;
        end else begin
            // The two strobes are single-cycle by default and are raised only
            // on the transitions into SEED and NEXT.
            seed_valid <= 1'b0;
            iter_start <= 1'b0;

            unique case (state)
                S_IDLE, S_DONE: begin
                    if (launch) begin
                        state     <= S_INIT;
                        seed_v_id <= root_v_id;
                        iter_id   <= '0;
                        upd_count <= '0;
                        end_mask  <= '0;
                        cap_hit   <= 1'b0;
                        core_rst  <= '1;
                        rst_cnt   <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end

                S_INIT: begin
                    if (rst_cnt == RST_LAST) begin
                        state      <= S_SEED;
                        core_rst   <= '0;
                        seed_valid <= 1'b1;
                        iter_start <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt + 4'd1;
                    end
                end

                S_SEED: begin
                    state <= S_RUN;
                end

                S_RUN: begin
                    upd_count <= upd_sat;
                    end_mask  <= mask_merged;
                    // The watchdog wins over a mask that completes in the
                    // same cycle.
                    if (wd_expire) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (mask_full) begin
                        state <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    // The decision uses the count registered at the end of
                    // RUN, which already includes any update that arrived with
                    // the final end. Updates seen during CHECK are still added.
                    upd_count <= upd_sat;
                    if (upd_count == '0) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (iter_id == ITER_CAP) begin
                        state   <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        cap_hit <= 1'b1;
                    end else begin
                        state      <= S_NEXT;
                        iter_id    <= iter_id + 1'b1;
                        iter_start <= 1'b1;
                        end_mask   <= '0;
                        upd_count  <= '0;
                    end
                end

                S_NEXT: begin
                    state <= S_RUN;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Per-iteration watchdog
    // -------------------------------------------------------------------------
`ifdef ITER_TIMEOUT_EN
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            timeout_q;

    // wd_cnt counts RUN cycles since the last iter_start. It equals WD_LAST
    // during the TIMEOUT_CYCLES-th RUN cycle, and DONE follows that cycle.
    assign wd_expire = (state == S_RUN) && (wd_cnt == WD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (iter_start) begin
                wd_cnt <= '0;
            end else if (state == S_RUN) begin
                wd_cnt <= wd_cnt + 1'b1;
            end

            if (launch) begin
                timeout_q <= 1'b0;
            end else if (wd_expire) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign wd_expire = 1'b0;
    assign timeout   = 1'b0;
`endif

endmodule

// File: doc/bfs_iteration_ctrl.md
# bfs_iteration_ctrl

Top-level BFS iteration sequencer that drives the per-core apply/iteration-end stage. It resets the cores, seeds the root vertex, and tracks iteration-end across all cores with a sticky per-core mask. It counts updated active vertices in each iteration, then either opens the next iteration or declares convergence. It sits above the per-core pipeline: it consumes that pipeline's active-vertex and iteration-end outputs and generates the per-core `rst` vector and iteration control for the front of the pipeline.

## Interface
- `CORE_NUM`, 32, number of cores; power of two, 2..64.
- `V_ID_WIDTH`, 32, vertex id width.
- `ITER_WIDTH`, 16, iteration counter width.
- `MAX_ITER`, 65535, iteration cap; must be less than or equal to 2^ITER_WIDTH-1.
- `RST_CYCLES`, 4, core reset pulse length, 1..15.
- `TIMEOUT_CYCLES`, 2^20, per-iteration watchdog limit; used only with `ITER_TIMEOUT_EN`.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle launch pulse; ignored unless in IDLE or DONE.
- `root_v_id` in V_ID_WIDTH: root vertex; sampled on the accepted `start`.
- `active_v_valid` in CORE_NUM: per-core active-vertex valid.
- `active_v_updated` in CORE_NUM: per-core active-vertex updated flag.
- `iteration_end` in CORE_NUM: per-core end flag.
- `iteration_end_valid` in CORE_NUM: qualifies `iteration_end`.
- `core_rst` out CORE_NUM: synchronous, active-high reset to the cores; all bits equal.
- `seed_v_id` out V_ID_WIDTH: root id, valid with `seed_valid`.
- `seed_valid` out 1: one-cycle root injection.
- `iter_start` out 1: one-cycle pulse opening each iteration, including the first.
- `iter_id` out ITER_WIDTH: current iteration index, starting at 0.
- `upd_count` out 32: updated-vertex count for the current iteration; saturates at 2^32-1.
- `busy` out 1: high in every state except IDLE and DONE.
- `done` out 1: level, high in DONE.
- `cap_hit` out 1: DONE was reached via `MAX_ITER`.
- `timeout` out 1: DONE was reached via the watchdog.

## Operation
- States are IDLE, INIT, SEED, RUN, CHECK, NEXT and DONE.
- IDLE/DONE --`start`--> INIT.
  - Latch `root_v_id`.
  - Clear `iter_id`, `upd_count`, the end mask, `cap_hit` and `timeout`.
- INIT: `core_rst` is all-ones for exactly `RST_CYCLES` cycles, then -> SEED.
- SEED: `seed_valid`=1 and `iter_start`=1 for one cycle, then -> RUN.
- RUN, end mask:
  - `end_mask[i]` sets when `iteration_end_valid[i] && iteration_end[i]`.
  - Bits stay set until NEXT or INIT.
  - Valid-qualified `iteration_end`=0 does not clear a set bit.
- RUN, update counting:
  - Each cycle, `upd_count` += popcount(`active_v_valid & active_v_updated`), saturating.
  - Counting happens only in RUN and CHECK; inputs seen in any other state are dropped.
- RUN -> CHECK when `end_mask` is all-ones. This includes the cycle in which the final bit is set, using the combinational OR of the mask and the incoming ends.
- CHECK is one cycle, with priority:
  1. `upd_count`==0 -> DONE (converged).
  2. `iter_id`==`MAX_ITER` -> DONE with `cap_hit`=1.
  3. Otherwise -> NEXT.
- CHECK and same-cycle updates: an update arriving in the same cycle the mask completes is counted before CHECK evaluates.
- NEXT, one cycle:
  - `iter_id`++ and `iter_start`=1.
  - Clear `end_mask` and `upd_count`.
  - -> RUN.
- DONE: `iter_id` and `upd_count` hold for readout. `start` relaunches.
- `start` while busy is ignored; it has no effect on state, counters or flags.
- Asynchronous reset deassertion mid-run resumes in IDLE with all counters cleared.

## Timing
- Reset values:
  - State IDLE.
  - `core_rst`=all-ones, so cores are held in reset until INIT completes.
  - `seed_v_id`=0 and `seed_valid`=0.
  - `iter_start`=0, `iter_id`=0, `upd_count`=0.
  - `busy`=0, `done`=0, `cap_hit`=0, `timeout`=0.
- `core_rst` deasserts on the cycle SEED is entered and stays low until the next INIT.
- All outputs are registered.
- Cycle sequence from `start` at cycle 0:
  - INIT occupies cycles 1..RST_CYCLES.
  - `seed_valid`/`iter_start` at cycle RST_CYCLES+1.
  - RUN from cycle RST_CYCLES+2.
- From the last end bit to `done`: 2 cycles (RUN->CHECK->DONE).
- From the last end bit to the next `iter_start`: 2 cycles (RUN->CHECK->NEXT).
- The popcount is a combinational adder tree feeding one register stage. No latency is added to the end-mask path.

## Configuration
- `ITER_TIMEOUT_EN` defined:
  - A watchdog counter clears on every `iter_start` and increments in RUN.
  - On reaching `TIMEOUT_CYCLES` the FSM goes -> DONE with `timeout`=1, taking priority over a same-cycle mask completion.
- Not defined: no watchdog logic; `timeout` is tied to 0 and RUN waits indefinitely.

## Test plan
- CORE_NUM=32, RST_CYCLES=4, `start` with root=5:
  - `core_rst` high for cycles 1-4.
  - `seed_v_id`=5 with `seed_valid` at cycle 5.
  - `iter_id`=0.
- Iteration 0: 3 updated vertices spread over cores 0/7/31, then all cores end:
  - `upd_count`=3.
  - `iter_start` 2 cycles after the final end, with `iter_id`=1.
- Iteration 1: zero updates, then all cores end → `done`=1 two cycles after the final end, `cap_hit`=0, `iter_id`=1.
- Staggered ends: core 3 pulses end and later presents valid end=0; all others end later → the sticky mask completes and CHECK is reached once.
- MAX_ITER=2 with updates every iteration → DONE at `iter_id`=2 with `cap_hit`=1; a `start` mid-RUN is ignored.
- With `ITER_TIMEOUT_EN` and TIMEOUT_CYCLES=100, core 9 never ends → `timeout`=1 and `done`=1 exactly 100 RUN cycles after `iter_start`; async reset then returns all outputs to reset values.
